// File: rtl/pu_tag_lookup_engine.sv
// Tag lookup engine: hashes up to 8 tags per request into the tag table, compares the returned
// keys and emits one result per tag followed by one status per request.
module pu_tag_lookup_engine #(
  parameter int NUM_OF_PU       = 8,
  parameter int PU_ID_NBITS     = 3,
  parameter int RCI_NBITS       = 8,
  parameter int TAG_NBITS       = 16,
  parameter int TBL_DEPTH_NBITS = 10,
  parameter int TBL_LAT         = 2
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_req_valid,
  output logic                                 o_req_ready,
  input  logic [PU_ID_NBITS-1:0]               i_req_pid,
  input  logic [3:0]                           i_req_cnt,
  input  logic [8*TAG_NBITS-1:0]               i_req_tags,
  output logic                                 o_tbl_rd,
  output logic [TBL_DEPTH_NBITS-1:0]           o_tbl_addr,
  input  logic [TAG_NBITS+RCI_NBITS:0]         i_tbl_rdata,
  output logic                                 o_tag_lookup_valid,
  output logic [RCI_NBITS-1:0]                 o_tag_lookup_result,
  output logic [2:0]                           o_tag_lookup_result_num,
  output logic [PU_ID_NBITS-1:0]               o_tag_lookup_result_pid,
  output logic                                 o_tag_lookup_status_valid,
  output logic [3:0]                           o_tag_lookup_status,
  output logic [PU_ID_NBITS-1:0]               o_tag_lookup_status_pid
);

  // state    | meaning
  // S_IDLE   | ready for a new request
  // S_ISSUE  | one table read per cycle, tags 0..cnt-1
  // S_DRAIN  | waiting for the remaining results to leave the read pipe
  // S_STATUS | request status driven for one cycle
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_STATUS} state_t;

  if (NUM_OF_PU > (1 << PU_ID_NBITS)) begin : g_pid_width_check
    $error("NUM_OF_PU does not fit in PU_ID_NBITS");
  end

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic [PU_ID_NBITS-1:0]       r_pid;
  logic [3:0]                   r_cnt;
  logic [8*TAG_NBITS-1:0]       r_tags;
  logic [2:0]                   r_idx;
  logic                         r_pv [TBL_LAT];
  logic [2:0]                   r_pi [TBL_LAT];
  logic                         r_res_valid;
  logic [RCI_NBITS-1:0]         r_res_rci;
  logic [2:0]                   r_res_num;
  logic [PU_ID_NBITS-1:0]       r_res_pid;
  logic                         r_any_miss;

  logic                         w_ready;
  logic                         w_accept;
  logic [3:0]                   w_cnt_clamp;
  logic [TAG_NBITS-1:0]         w_issue_tag;
  logic [TBL_DEPTH_NBITS-1:0]   w_addr;
  logic                         w_rd_vld;
  logic [2:0]                   w_rd_idx;
  logic [TAG_NBITS-1:0]         w_cmp_tag;
  logic                         w_ent_vld;
  logic [TAG_NBITS-1:0]         w_ent_key;
  logic [RCI_NBITS-1:0]         w_ent_rci;
  logic                         w_hit;
  logic                         w_status_valid;

  assign w_ready     = (r_state == S_IDLE);
  assign w_accept    = i_req_valid & w_ready;
  assign w_cnt_clamp = (i_req_cnt > 4'd8) ? 4'd8 : i_req_cnt;

  // Fold the upper tag bits onto the table index.
  assign w_issue_tag = r_tags[int'(r_idx)*TAG_NBITS +: TAG_NBITS];
  assign w_addr      = w_issue_tag[TBL_DEPTH_NBITS-1:0]
                     ^ TBL_DEPTH_NBITS'(w_issue_tag >> TBL_DEPTH_NBITS);

  assign w_rd_vld  = r_pv[TBL_LAT-1];
  assign w_rd_idx  = r_pi[TBL_LAT-1];
  assign w_cmp_tag = r_tags[int'(w_rd_idx)*TAG_NBITS +: TAG_NBITS];
  assign w_ent_vld = i_tbl_rdata[TAG_NBITS+RCI_NBITS];
  assign w_ent_key = i_tbl_rdata[RCI_NBITS +: TAG_NBITS];
  assign w_ent_rci = i_tbl_rdata[RCI_NBITS-1:0];
  assign w_hit     = w_ent_vld && (w_ent_key == w_cmp_tag);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = (w_cnt_clamp == 4'd0) ? S_STATUS : S_ISSUE;
      S_ISSUE:  if ({1'b0, r_idx} == r_cnt - 4'd1) w_state_nxt = S_DRAIN;
      S_DRAIN:  if (r_res_valid && ({1'b0, r_res_num} == r_cnt - 4'd1)) w_state_nxt = S_STATUS;
      S_STATUS: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_pid       <= '0;
      r_cnt       <= '0;
      r_tags      <= '0;
      r_idx       <= '0;
      r_res_valid <= 1'b0;
      r_res_rci   <= '0;
      r_res_num   <= '0;
      r_res_pid   <= '0;
      r_any_miss  <= 1'b0;
      for (int k = 0; k < TBL_LAT; k++) begin
        r_pv[k] <= 1'b0;
        r_pi[k] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_pid  <= i_req_pid;
        r_cnt  <= w_cnt_clamp;
        r_tags <= i_req_tags;
        r_idx  <= '0;
      end else if (o_tbl_rd) begin
        r_idx <= r_idx + 3'd1;
      end
      // Valid/index pipe stays aligned with the table read latency.
      r_pv[0] <= o_tbl_rd;
      r_pi[0] <= r_idx;
      for (int k = 1; k < TBL_LAT; k++) begin
        r_pv[k] <= r_pv[k-1];
        r_pi[k] <= r_pi[k-1];
      end
      r_res_valid <= w_rd_vld;
      r_res_rci   <= (w_rd_vld && w_hit) ? w_ent_rci : '0;
      r_res_num   <= w_rd_vld ? w_rd_idx : 3'd0;
      r_res_pid   <= w_rd_vld ? r_pid : '0;
      if (w_accept) r_any_miss <= 1'b0;
      else if (w_rd_vld && !w_hit) r_any_miss <= 1'b1;
    end
  end

  assign w_status_valid = (r_state == S_STATUS);

  assign o_req_ready               = w_ready;
  assign o_tbl_rd                  = (r_state == S_ISSUE);
  assign o_tbl_addr                = o_tbl_rd ? w_addr : '0;
  assign o_tag_lookup_valid        = r_res_valid;
  assign o_tag_lookup_result       = r_res_rci;
  assign o_tag_lookup_result_num   = r_res_num;
  assign o_tag_lookup_result_pid   = r_res_pid;
  assign o_tag_lookup_status_valid = w_status_valid;
  assign o_tag_lookup_status       = w_status_valid ? {1'b0, (r_cnt == 4'd0), r_any_miss, 1'b1} : 4'd0;
  assign o_tag_lookup_status_pid   = w_status_valid ? r_pid : '0;

endmodule
